// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and stage-register layout for the memory-access stage.
package mem_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        we;
    logic        load;
    logic [2:0]  funct3;
    logic        rf_we;
    logic [1:0]  wd_sel;
    logic [4:0]  wr;
    logic [31:0] pc4;
  } stage_t;

  // Bytes may sit anywhere; halfwords need even addresses, words need 4-byte alignment.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic res;
    case (funct3)
      LS_H, LS_HU: res = addr_lo[0];
      LS_W:        res = (addr_lo != 2'b00);
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] wb_select(input logic [1:0]  wd_sel,
                                            input logic [31:0] alu,
                                            input logic [31:0] mem,
                                            input logic [31:0] pc4);
    logic [31:0] res;
    case (wd_sel)
      WD_ALU:  res = alu;
      WD_MEM:  res = mem;
      WD_PC4:  res = pc4;
      default: res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  assign lane = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      LS_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      LS_BU:   data_o = {24'h000000, lane[7:0]};
      LS_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      LS_HU:   data_o = {16'h0000, lane[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM stage register plus the data-memory access FSM; stalls upstream while a
// request is outstanding and presents a registered write-back slot.
module mem_stage
  import mem_pkg::*;
#(
  parameter int RESP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rD2_i,
  input  logic        dram_we_i,
  input  logic        is_load_i,
  input  logic [2:0]  ls_funct3_i,
  input  logic        rf_we_i,
  input  logic [1:0]  wd_sel_i,
  input  logic [4:0]  wr_i,
  input  logic [31:0] pc4_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        wb_valid_o,
  output logic        wb_rf_we_o,
  output logic [4:0]  wb_wr_o,
  output logic [31:0] wb_wd_o,
  output logic        misaligned_o,
  output logic        err_o
);

  localparam int CW = $clog2(RESP_TIMEOUT + 1);

  mem_state_t    state_q;
  stage_t        s_q, s_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   acc_addr_q, acc_pc4_q, wdata_q, wdata_d;
  logic          acc_we_q, acc_rf_we_q;
  logic [2:0]    acc_funct3_q;
  logic [1:0]    acc_wd_sel_q;
  logic [4:0]    acc_wr_q;
  logic [3:0]    be_q, be_d;
  logic          wb_valid_q, wb_rf_we_q, mis_q, err_q;
  logic [4:0]    wb_wr_q;
  logic [31:0]   wb_wd_q, load_data;
  logic          in_access, s_memop, s_mis, timeout;

  assign in_access = (state_q == ACCESS);
  assign s_memop   = s_q.valid & (s_q.we | s_q.load);
  assign s_mis     = misaligned(s_q.funct3, s_q.addr[1:0]);
  assign timeout   = (cnt_q == CW'(RESP_TIMEOUT - 1));

  always_comb begin
    s_d = '0;
    if (ex_valid_i) begin
      s_d.valid  = 1'b1;
      s_d.addr   = alu_result_i;
      s_d.sdata  = rD2_i;
      s_d.we     = dram_we_i;
      s_d.load   = is_load_i;
      s_d.funct3 = ls_funct3_i;
      s_d.rf_we  = rf_we_i;
      s_d.wd_sel = wd_sel_i;
      s_d.wr     = wr_i;
      s_d.pc4    = pc4_i;
    end
  end

  // Store lanes are replicated so the memory can pick any enabled byte position.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (s_q.we) begin
      case (s_q.funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << s_q.addr[1:0];
          wdata_d = {4{s_q.sdata[7:0]}};
        end
        2'b01: begin
          be_d    = s_q.addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{s_q.sdata[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = s_q.sdata;
        end
      endcase
    end
  end

  mem_load_align u_align (
    .addr_lo_i (acc_addr_q[1:0]),
    .funct3_i  (acc_funct3_q),
    .rdata_i   (dmem_rdata_i),
    .data_o    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s_q          <= '0;
      cnt_q        <= '0;
      acc_addr_q   <= '0;
      acc_pc4_q    <= '0;
      acc_we_q     <= 1'b0;
      acc_rf_we_q  <= 1'b0;
      acc_funct3_q <= '0;
      acc_wd_sel_q <= '0;
      acc_wr_q     <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_rf_we_q   <= 1'b0;
      wb_wr_q      <= '0;
      wb_wd_q      <= '0;
      mis_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (!stall_o) s_q <= s_d;
      wb_valid_q <= 1'b0;
      wb_rf_we_q <= 1'b0;
      wb_wr_q    <= '0;
      wb_wd_q    <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s_q.valid) begin
            if (s_memop && !s_mis) begin
              state_q      <= ACCESS;
              cnt_q        <= '0;
              acc_addr_q   <= s_q.addr;
              acc_pc4_q    <= s_q.pc4;
              acc_we_q     <= s_q.we;
              acc_rf_we_q  <= s_q.rf_we;
              acc_funct3_q <= s_q.funct3;
              acc_wd_sel_q <= s_q.wd_sel;
              acc_wr_q     <= s_q.wr;
              be_q         <= be_d;
              wdata_q      <= wdata_d;
            end else begin
              wb_valid_q <= 1'b1;
              wb_rf_we_q <= s_q.rf_we && !s_memop && (s_q.wr != 5'd0);
              wb_wr_q    <= s_q.wr;
              wb_wd_q    <= wb_select(s_q.wd_sel, s_q.addr, 32'h0, s_q.pc4);
              mis_q      <= s_memop;
            end
          end
        end
        ACCESS: begin
          // Ready is checked first so a response on the final allowed cycle still completes.
          if (dmem_ready_i) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_rf_we_q <= acc_rf_we_q && (acc_wr_q != 5'd0);
            wb_wr_q    <= acc_wr_q;
            wb_wd_q    <= wb_select(acc_wd_sel_q, acc_addr_q, load_data, acc_pc4_q);
          end else if (timeout) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_wr_q    <= acc_wr_q;
            wb_wd_q    <= wb_select(acc_wd_sel_q, acc_addr_q, 32'h0, acc_pc4_q);
            err_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign stall_o      = in_access & ~dmem_ready_i;
  assign dmem_req_o   = in_access;
  assign dmem_we_o    = in_access & acc_we_q;
  assign dmem_addr_o  = in_access ? {acc_addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_be_o    = in_access ? be_q : 4'b0000;
  assign dmem_wdata_o = in_access ? wdata_q : 32'h0;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rf_we_o   = wb_rf_we_q;
  assign wb_wr_o      = wb_wr_q;
  assign wb_wd_o      = wb_wd_q;
  assign misaligned_o = mis_q;
  assign err_o        = err_q;

endmodule
